// File: rtl/layer_sequencer_if.sv
// Bundle between the layer sequencer, its weight memory and the neuron stage.
//   master (sequencer side): drives w_addr, w_en, w_vec, y_vec;
//                            receives w_rdata, neuron_value.
//   slave  (memory/neuron side): the mirror image.
//   w_addr        weight row address
//   w_en          weight memory read enable
//   w_rdata       weight row, valid the cycle after w_en
//   w_vec         registered weight row to the neuron stage
//   y_vec         registered layer input vector to the neuron stage
//   neuron_value  signed neuron result, combinational from w_vec/y_vec
interface layer_sequencer_if #(
    parameter int VEC_LEN = 16,
    parameter int ADDR_W  = 3
);
    logic [ADDR_W-1:0]      w_addr;
    logic                   w_en;
    logic [VEC_LEN*32-1:0]  w_rdata;
    logic [VEC_LEN*32-1:0]  w_vec;
    logic [VEC_LEN*32-1:0]  y_vec;
    logic signed [31:0]     neuron_value;

    modport master (
        output w_addr, w_en, w_vec, y_vec,
        input  w_rdata, neuron_value
    );

    modport slave (
        input  w_addr, w_en, w_vec, y_vec,
        output w_rdata, neuron_value
    );
endinterface

// File: rtl/layer_sequencer.sv
// Fully-connected layer sequencer: time-multiplexes one neuron stage over
// NUM_NEURONS weight rows. The input vector is latched on start, each row is
// fetched from a synchronous memory, presented to the neuron stage, and the
// returned value is stored in the matching out_vec slot. 3 cycles per neuron.
// Ports:
//   clk      system clock, rising edge
//   reset    synchronous active-high reset
//   start    begin a layer (only looked at in IDLE)
//   in_vec   layer input, element i at [32*i+31:32*i]
//   bus      memory / neuron stage bundle (master side)
//   out_vec  results, neuron n at [32*n+31:32*n]
//   busy     high in every state except IDLE
//   done     one-cycle pulse when out_vec is complete
// ADDR_W must satisfy 2**ADDR_W >= NUM_NEURONS.
//
// state | meaning
// IDLE  | waiting for start, out_vec holds last result
// READ  | w_en high, w_addr = idx
// WAIT  | memory data arriving, captured into w_vec
// EVAL  | neuron_value settled, written to slot idx
// DONE  | done pulse, back to IDLE
module layer_sequencer #(
    parameter int VEC_LEN     = 16,
    parameter int NUM_NEURONS = 8,
    parameter int ADDR_W      = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [VEC_LEN*32-1:0]      in_vec,
    layer_sequencer_if.master          bus,
    output logic [NUM_NEURONS*32-1:0]  out_vec,
    output logic                       busy,
    output logic                       done
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        WAIT = 3'd2,
        EVAL = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_NEURONS - 1);

    state_t            state;
    logic [ADDR_W-1:0] idx;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= '0;
            bus.w_addr <= '0;
            bus.w_en   <= 1'b0;
            bus.w_vec  <= '0;
            bus.y_vec  <= '0;
            out_vec    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        bus.y_vec  <= in_vec;
                        idx        <= '0;
                        // Outputs are registered, so the READ-state values
                        // are set on the transition into READ.
                        bus.w_en   <= 1'b1;
                        bus.w_addr <= '0;
                        busy       <= 1'b1;
                        state      <= READ;
                    end
                end
                READ: begin
                    bus.w_en <= 1'b0;
                    state    <= WAIT;
                end
                WAIT: begin
                    bus.w_vec <= bus.w_rdata;
                    state     <= EVAL;
                end
                EVAL: begin
                    for (int n = 0; n < NUM_NEURONS; n++) begin
                        if (idx == ADDR_W'(n)) begin
                            out_vec[32*n +: 32] <= bus.neuron_value;
                        end
                    end
                    if (idx == LAST_IDX) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx        <= idx + ADDR_W'(1);
                        bus.w_en   <= 1'b1;
                        bus.w_addr <= idx + ADDR_W'(1);
                        state      <= READ;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    bus.w_en <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/layer_sequencer.md
Name: layer_sequencer

Overview:
- Sequential controller that evaluates one fully-connected layer by time-multiplexing a single neuron_operation instance.
- Latches the layer input vector, then fetches one weight row per neuron from a synchronous weight memory. Each row is presented together with the latched vector to the neuron stage, and the returned neuron_value is captured into an output vector register.
- Sits upstream of neuron_operation (drives w and y_out) and immediately downstream of it (consumes neuron_value).

Parameters:
- VEC_LEN, 16, number of 32-bit signed elements per input vector / weight row.
- NUM_NEURONS, 8, neurons in the layer (weight rows, output slots).
- ADDR_W, 3, weight memory address width; must satisfy 2**ADDR_W >= NUM_NEURONS.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin layer evaluation; sampled only in IDLE.
- in_vec  input  VEC_LEN*32  layer input activations, element i at bits [32*i+31:32*i], signed.
- w_addr  output  ADDR_W  weight row address to memory.
- w_en  output  1  weight memory read enable.
- w_rdata  input  VEC_LEN*32  weight row, valid the cycle after w_en.
- w_vec  output  VEC_LEN*32  registered weight row to neuron_operation.w.
- y_vec  output  VEC_LEN*32  registered input vector to neuron_operation.y_out.
- neuron_value  input  32  signed result from neuron_operation, combinational from w_vec/y_vec.
- out_vec  output  NUM_NEURONS*32  layer results, neuron n at bits [32*n+31:32*n].
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when out_vec is complete.

Behaviour:
- Reset: state=IDLE; idx, w_addr, w_vec, y_vec, out_vec all 0; w_en=0, busy=0, done=0.
- Reset asserted mid-operation aborts the layer, returns to IDLE next edge and clears out_vec; no done pulse is produced.
- IDLE:
  - When start=1: latch in_vec into y_vec, set idx=0, go to READ.
  - Otherwise hold; out_vec retains its last result.
- READ: w_en=1, w_addr=idx; go to WAIT.
- WAIT:
  - w_en=0; register w_rdata into w_vec; go to EVAL.
- EVAL:
  - w_vec and y_vec are stable, so neuron_value has settled combinationally.
  - At the edge, write neuron_value into out_vec slot idx.
  - If idx==NUM_NEURONS-1, go to DONE; else idx=idx+1 and go to READ.
- DONE: done=1 for exactly this cycle; go to IDLE.
- Timing: 3 cycles per neuron. With start sampled at edge 0, done is high during cycle 3*NUM_NEURONS+1 (cycle 25 for the default).
- Only slot idx is written in EVAL; all other slots hold.
- out_vec is not cleared on a new start. Slots are overwritten progressively and are valid as a set only from the done pulse until the next start.
- start while busy (READ/WAIT/EVAL/DONE) is ignored, not queued. A start held high through DONE is accepted on the following IDLE cycle.
- in_vec changes after the start edge have no effect (y_vec is latched).
- No arithmetic in this block; values pass through unmodified as 32-bit two's complement.
- w_addr holds its last value when w_en=0.

Test Plan:
- Reset mid-layer: assert reset during WAIT of neuron 2 -> next cycle busy=0, done=0, out_vec=0; a subsequent start runs the full layer normally.
- Single layer, VEC_LEN=4, NUM_NEURONS=3, in_vec={1,2,3,4}, rows {1,1,1,1},{-1,-1,-1,-1},{2,0,0,0}, with a behavioural neuron (ReLU, leaky divider 4):
  - out_vec={10,-2,2}.
  - done exactly one cycle, 10 cycles after start; w_addr sequence 0,1,2 with w_en one cycle each.
- Latency and handshake: count cycles from start to done for the default parameters -> exactly 25; busy high for cycles 1..25, low otherwise.
- start ignored while busy: pulse start during EVAL of neuron 1 -> no restart, a single done, out_vec unaffected. Holding start high continuously -> back-to-back layers separated by one IDLE cycle.
- in_vec stability: change in_vec to all 0 one cycle after start -> results still computed from the original {1,2,3,4}.
- Boundary NUM_NEURONS=1: single READ/WAIT/EVAL then done at cycle 4; idx never increments; only slot 0 written.
